hex_display_arbiter: RTL and testbench

- Shares the board's six seven-segment digits (HEX0..HEX5) and ten LEDs (LEDR) between up to NUM_REQ requesters, such as the FIFO test status, frame counters and debug probes.
- Uses a round-robin grant with a minimum hold time, so each requester's value stays readable by a person.
- Registers the granted requester's 24-bit hex value and 10-bit LED pattern, then drives them as active-low segment codes and active-high LEDs.
- Sits directly under the board top level, in place of hard-wired display assigns.

---
 rtl/hex_disp_pkg.sv | 35 +++
 rtl/hex_display_arbiter_seg7.sv | 15 +
 rtl/hex_display_arbiter.sv | 153 +++++++++++++++
 tb/tb_hex_display_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   SEG7      : active-low segment codes for hex digits 0..F, dp off.
//   SEG_BLANK : all segments off.
//   next_rr   : round-robin pick of the first set request after 'last'.
//   state_t   : arbiter FSM states.
package hex_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG7 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {IDLE, OWNED} state_t;

  // Scans n requesters starting at last+1 (mod n) and returns a one-hot
  // vector for the first one set, or zero when none is set. Sized for the
  // largest legal requester count; callers truncate to their own width.
  function automatic logic [7:0] next_rr(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         n);
    logic [7:0] pick;
    int         idx;
    pick = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && pick == '0) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) pick[idx[2:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_seg7.sv
// Combinational hex-digit to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-low segments, bit7 = dp (off), bits 6:0 = g..a
module hex_seg7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG7[nibble];
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing HEX0..HEX5 and LEDR between NUM_REQ
// requesters, with a minimum hold time so each value stays readable.
//   MAX10_CLK1_50 : 50 MHz system clock
//   reset_n       : asynchronous active-low reset
//   req           : per-requester level-sensitive display request
//   req_value     : 24 bits (six hex nibbles) per requester
//   req_led       : 10-bit LED pattern per requester
//   grant         : one-hot current owner, zero when idle
//   busy          : any grant active
//   HEX0..HEX5    : registered active-low segment codes
//   LEDR          : registered active-high LEDs
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                    MAX10_CLK1_50,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   req_value,
  input  logic [10*NUM_REQ-1:0]   req_led,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic [7:0]              HEX0,
  output logic [7:0]              HEX1,
  output logic [7:0]              HEX2,
  output logic [7:0]              HEX3,
  output logic [7:0]              HEX4,
  output logic [7:0]              HEX5,
  output logic [9:0]              LEDR
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]     last_q,  last_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [OWN_W-1:0]     owner;
  logic [NUM_REQ-1:0]   others;
  logic [23:0]          sel_value;
  logic [9:0]           sel_led;
  logic [7:0]           seg_c  [6];
  logic [7:0]           hex_p1 [6];
  logic [9:0]           led_p1;

  // Index of the current owner; only meaningful while grant_q is non-zero.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner = OWN_W'(i);
    end
  end

  // The owner is masked out so an expiry switch can never re-pick it.
  assign others = req & ~grant_q;

  // ---- stage p0: arbitration state ----
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = NUM_REQ'(next_rr(8'(req), 3'(last_q), NUM_REQ));
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!req[owner]) begin
          // A drop releases immediately, hold time or not; a same-edge
          // expiry lands here too and picks the same target.
          last_d = owner;
          if (|others) begin
            grant_d = NUM_REQ'(next_rr(8'(others), 3'(owner), NUM_REQ));
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q == '0 && |others) begin
          last_d  = owner;
          grant_d = NUM_REQ'(next_rr(8'(others), 3'(owner), NUM_REQ));
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant = grant_q;
    busy  = |grant_q;
  end

  assign sel_value = req_value[24*int'(owner) +: 24];
  assign sel_led   = req_led[10*int'(owner) +: 10];

  for (genvar k = 0; k < 6; k++) begin : g_dec
    hex_seg7_decode u_dec (
      .nibble (sel_value[4*k +: 4]),
      .seg    (seg_c[k])
    );
  end

  // ---- stage p1: registered display, follows the registered grant ----
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 6; k++) hex_p1[k] <= SEG_BLANK;
      led_p1 <= '0;
    end else if (|grant_q) begin
      for (int k = 0; k < 6; k++) hex_p1[k] <= seg_c[k];
      led_p1 <= sel_led;
    end else begin
      for (int k = 0; k < 6; k++) hex_p1[k] <= SEG_BLANK;
      led_p1 <= '0;
    end
  end

  assign HEX0 = hex_p1[0];
  assign HEX1 = hex_p1[1];
  assign HEX2 = hex_p1[2];
  assign HEX3 = hex_p1[3];
  assign HEX4 = hex_p1[4];
  assign HEX5 = hex_p1[5];
  assign LEDR = led_p1;

endmodule

// File: tb/tb_hex_display_arbiter.sv
module tb_hex_display_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam logic [47:0] BL = 48'hFFFF_FFFF_FFFF;

  logic         MAX10_CLK1_50 = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [23:0]  val [N];
  logic [9:0]   led [N];
  logic [24*N-1:0] req_value;
  logic [10*N-1:0] req_led;
  logic [N-1:0] grant;
  logic         busy;
  logic [7:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0]   LEDR;
  logic [47:0]  hex_all;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_owner;
  int          m_last;
  int          m_age;
  logic [47:0] m_hex;
  logic [9:0]  m_led;

  logic [7:0] tseg [16];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  g;
    logic [47:0] hex;
    logic [9:0]  led;
  } vec_t;
  vec_t tbl [14];

  assign req_value = {val[3], val[2], val[1], val[0]};
  assign req_led   = {led[3], led[2], led[1], led[0]};
  assign hex_all   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  hex_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .reset_n       (reset_n),
    .req           (req),
    .req_value     (req_value),
    .req_led       (req_led),
    .grant         (grant),
    .busy          (busy),
    .HEX0          (HEX0),
    .HEX1          (HEX1),
    .HEX2          (HEX2),
    .HEX3          (HEX3),
    .HEX4          (HEX4),
    .HEX5          (HEX5),
    .LEDR          (LEDR)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] enc(input logic [23:0] v);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[8*k +: 8] = tseg[v[4*k +: 4]];
    return r;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      if (r[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    m_hex   = BL;
    m_led   = '0;
  endtask

  // One clock edge of the arbiter as described by its rules: display shows
  // whoever owned the bus before the edge, then ownership is re-decided.
  task automatic model_step();
    logic [3:0] oth;
    if (m_owner >= 0) begin
      m_hex = enc(val[m_owner]);
      m_led = led[m_owner];
    end else begin
      m_hex = BL;
      m_led = '0;
    end
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = rr_pick(req, m_last);
        m_age   = 1;
      end
    end else begin
      oth = req & ~4'(1 << m_owner);
      if (!req[m_owner] || (m_age >= HOLD && oth != 0)) begin
        m_last  = m_owner;
        m_owner = rr_pick(oth, m_owner);
        m_age   = 1;
      end else if (m_age < HOLD) begin
        m_age++;
      end
    end
  endtask

  task automatic tick();
    @(posedge MAX10_CLK1_50);
    model_step();
    #1;
    chk("grant", 48'(grant), 48'(m_grant()));
    chk("busy",  48'(busy),  48'(m_owner >= 0));
    chk("hex",   hex_all,    m_hex);
    chk("ledr",  48'(LEDR),  48'(m_led));
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 48'(grant), 48'h0);
    chk("rst_busy",  48'(busy),  48'h0);
    chk("rst_hex",   hex_all,    BL);
    chk("rst_ledr",  48'(LEDR),  48'h0);
    model_reset();
    @(negedge MAX10_CLK1_50);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tseg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    //          req      grant    {HEX5..HEX0}        LEDR
    tbl[0]  = '{4'b0001, 4'b0001, BL,                 10'h000};
    tbl[1]  = '{4'b0001, 4'b0001, 48'hC0F9A4B0888E,   10'h155};
    tbl[2]  = '{4'b0000, 4'b0000, 48'hC0F9A4B0888E,   10'h155};
    tbl[3]  = '{4'b0000, 4'b0000, BL,                 10'h000};
    tbl[4]  = '{4'b0011, 4'b0010, BL,                 10'h000};
    tbl[5]  = '{4'b0011, 4'b0010, 48'h999282F88090,   10'h2AA};
    tbl[6]  = '{4'b0011, 4'b0010, 48'h999282F88090,   10'h2AA};
    tbl[7]  = '{4'b0011, 4'b0010, 48'h999282F88090,   10'h2AA};
    tbl[8]  = '{4'b0011, 4'b0001, 48'h999282F88090,   10'h2AA};
    tbl[9]  = '{4'b0011, 4'b0001, 48'hC0F9A4B0888E,   10'h155};
    tbl[10] = '{4'b0011, 4'b0001, 48'hC0F9A4B0888E,   10'h155};
    tbl[11] = '{4'b0011, 4'b0001, 48'hC0F9A4B0888E,   10'h155};
    tbl[12] = '{4'b0011, 4'b0010, 48'hC0F9A4B0888E,   10'h155};
    tbl[13] = '{4'b0011, 4'b0010, 48'h999282F88090,   10'h2AA};

    val[0] = 24'h0123AF; led[0] = 10'h155;
    val[1] = 24'h456789; led[1] = 10'h2AA;
    val[2] = 24'hBCDE01; led[2] = 10'h3FF;
    val[3] = 24'hFEDCBA; led[3] = 10'h001;
    req     = '0;
    reset_n = 1'b0;
    model_reset();
    #25;
    chk("init_grant", 48'(grant), 48'h0);
    chk("init_busy",  48'(busy),  48'h0);
    chk("init_hex",   hex_all,    BL);
    chk("init_ledr",  48'(LEDR),  48'h0);
    @(negedge MAX10_CLK1_50);
    reset_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 10; i++) tick();
    chk("idle_grant", 48'(grant), 48'h0);
    chk("idle_hex",   hex_all,    BL);

    // directed table: single grant, release, two-way toggle with hold
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_grant", i), 48'(grant), 48'(tbl[i].g));
      chk($sformatf("tbl%0d_hex", i),   hex_all,    tbl[i].hex);
      chk($sformatf("tbl%0d_ledr", i),  48'(LEDR),  48'(tbl[i].led));
    end
    req = '0;
    tick();
    tick();

    // owner 2 drops while requester 0 waits: immediate move, fresh hold
    do_reset();
    req = 4'b0100; tick();
    chk("drop_g2", 48'(grant), 48'h4);
    req = 4'b0101; tick();
    chk("drop_hold2", 48'(grant), 48'h4);
    req = 4'b0001; tick();
    chk("drop_to0", 48'(grant), 48'h1);
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_reload", 48'(grant), 48'h1);
    end
    tick();
    chk("drop_expire", 48'(grant), 48'h4);

    // mid-grant asynchronous reset, then all requesting
    do_reset();
    req = 4'b1111; tick();
    chk("post_rst_g", 48'(grant), 48'h1);

    // sole requester keeps the grant past its hold time
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sole_g3", 48'(grant), 48'h8);
    end
    req = 4'b0000; tick();
    chk("sole_drop", 48'(grant), 48'h0);
    tick();
    chk("sole_blank", hex_all, BL);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        val[j] = 24'($urandom);
        led[j] = 10'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
